// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - class flag indices, state encoding and exponent helpers for fp_div
package fp_div_pkg;

  localparam int NTYPES    = 6;
  localparam int SNAN      = 0;
  localparam int QNAN      = 1;
  localparam int INFINITY  = 2;
  localparam int ZERO      = 3;
  localparam int SUBNORMAL = 4;
  localparam int NORMAL    = 5;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM} divState_e;

  function automatic int fpBias(input int nexp);
    return (1 << (nexp - 1)) - 1;
  endfunction

  function automatic logic [NTYPES-1:0] flagOf(input int idx);
    return NTYPES'(1) << idx;
  endfunction

endpackage

// File: rtl/fp_class.sv
// rtl/fp_class.sv - one-hot class of a floating-point magnitude (sign excluded)
module fp_class
  import fp_div_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic [NEXP+NSIG-1:0] mag,
  output logic [NTYPES-1:0]    flags
);

  logic [NEXP-1:0] expField;
  logic [NSIG-1:0] fracField;

  assign expField  = mag[NEXP+NSIG-1:NSIG];
  assign fracField = mag[NSIG-1:0];

  always_comb begin
    flags = '0;
    if (&expField) begin
      if (fracField == '0)        flags[INFINITY] = 1'b1;
      else if (fracField[NSIG-1]) flags[QNAN]     = 1'b1;
      else                        flags[SNAN]     = 1'b1;
    end else if (expField == '0) begin
      if (fracField == '0) flags[ZERO]      = 1'b1;
      else                 flags[SUBNORMAL] = 1'b1;
    end else begin
      flags[NORMAL] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_sig_div.sv
// rtl/fp_sig_div.sv - restoring significand divider, one quotient bit per step, MSB first
module fp_sig_div #(
  parameter int NSIG = 10,
  parameter int CW   = $clog2(NSIG + 3)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [NSIG:0]   dividend,
  input  logic [NSIG:0]   divisor,
  output logic [NSIG+1:0] quot,
  output logic [CW-1:0]   count
);

  logic [NSIG+1:0] rem;
  logic [NSIG:0]   divReg;
  logic [NSIG+2:0] trial;
  logic            ge;

  // Remainder stays below 2*divisor, so NSIG+2 bits hold it after the shift.
  assign trial = {1'b0, rem} - {2'b00, divReg};
  assign ge    = ~trial[NSIG+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= '0;
      divReg <= '0;
      quot   <= '0;
      count  <= '0;
    end else if (load) begin
      rem    <= {1'b0, dividend};
      divReg <= divisor;
      quot   <= '0;
      count  <= '0;
    end else if (step) begin
      rem   <= (ge ? trial[NSIG+1:0] : rem) << 1;
      quot  <= {quot[NSIG:0], ge};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fp_div.sv
// rtl/fp_div.sv - iterative truncating floating-point divider with start/done handshake
module fp_div
  import fp_div_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NEXP+NSIG:0]   a,
  input  logic [NEXP+NSIG:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [NEXP+NSIG:0]   q,
  output logic [NTYPES-1:0]    qFlags
);

  localparam int EW   = NEXP + 2;
  localparam int CW   = $clog2(NSIG + 3);
  localparam int BIAS = fpBias(NEXP);
  localparam logic signed [EW-1:0] EMIN  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EMAX  = EW'(BIAS);
  localparam logic signed [EW-1:0] ZLIM  = EW'(1 - BIAS - NSIG);
  localparam logic signed [EW-1:0] BIASX = EW'(BIAS);
  localparam logic [CW-1:0]        LASTCNT = CW'(NSIG + 1);

  divState_e state;
  logic [NTYPES-1:0] aF, bF;
  logic qSign, qSignR, isSpecial, load, aZero, bZero;
  logic signed [EW-1:0] t1Exp, t2Exp, shAmt, biasedExp;
  logic [NSIG+1:0] quot;
  logic [CW-1:0] count;
  logic [NSIG:0] tSig;
  logic [NSIG-1:0] subFrac;
  logic [NEXP+NSIG:0] specQ, normQ;
  logic [NTYPES-1:0] specFlags, normFlags;

  fp_class #(.NEXP(NEXP), .NSIG(NSIG)) uClassA (.mag(a[NEXP+NSIG-1:0]), .flags(aF));
  fp_class #(.NEXP(NEXP), .NSIG(NSIG)) uClassB (.mag(b[NEXP+NSIG-1:0]), .flags(bF));

  assign qSign = a[NEXP+NSIG] ^ b[NEXP+NSIG];
  // Subnormal operands are flushed to zero before any special-case decision.
  assign aZero = aF[ZERO] | aF[SUBNORMAL];
  assign bZero = bF[ZERO] | bF[SUBNORMAL];
  assign isSpecial = ~(aF[NORMAL] & bF[NORMAL]);
  assign load = (state == IDLE) && start && !isSpecial;

  always_comb begin
    specQ     = {qSign, {(NEXP+NSIG){1'b0}}};
    specFlags = flagOf(ZERO);
    if (aF[SNAN] || bF[SNAN]) begin
      specQ     = aF[SNAN] ? a : b;
      specFlags = flagOf(SNAN);
    end else if (aF[QNAN] || bF[QNAN]) begin
      specQ     = aF[QNAN] ? a : b;
      specFlags = flagOf(QNAN);
    end else if ((aF[INFINITY] && bF[INFINITY]) || (aZero && bZero)) begin
      specQ     = {qSign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      specFlags = flagOf(QNAN);
    end else if (aF[INFINITY] || bZero) begin
      specQ     = {qSign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      specFlags = flagOf(INFINITY);
    end
  end

  fp_sig_div #(.NSIG(NSIG), .CW(CW)) uSigDiv (
    .clk(clk), .rst_n(rst_n), .load(load), .step(state == DIVIDE),
    .dividend({1'b1, a[NSIG-1:0]}), .divisor({1'b1, b[NSIG-1:0]}),
    .quot(quot), .count(count)
  );

  always_comb begin
    if (quot[NSIG+1]) begin
      tSig  = quot[NSIG+1:1];
      t2Exp = t1Exp;
    end else begin
      tSig  = quot[NSIG:0];
      t2Exp = t1Exp - EW'(1);
    end
    shAmt     = EMIN - t2Exp;
    biasedExp = t2Exp + BIASX;
    subFrac   = NSIG'(tSig >> shAmt);
    if (t2Exp < ZLIM) begin
      normQ     = {qSignR, {(NEXP+NSIG){1'b0}}};
      normFlags = flagOf(ZERO);
    end else if (t2Exp < EMIN) begin
      normQ     = {qSignR, {NEXP{1'b0}}, subFrac};
      normFlags = flagOf(SUBNORMAL);
    end else if (t2Exp > EMAX) begin
      normQ     = {qSignR, {NEXP{1'b1}}, {NSIG{1'b0}}};
      normFlags = flagOf(INFINITY);
    end else begin
      normQ     = {qSignR, biasedExp[NEXP-1:0], tSig[NSIG-1:0]};
      normFlags = flagOf(NORMAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      q      <= '0;
      qFlags <= '0;
      qSignR <= 1'b0;
      t1Exp  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (isSpecial) begin
            q      <= specQ;
            qFlags <= specFlags;
            done   <= 1'b1;
          end else begin
            qSignR <= qSign;
            t1Exp  <= $signed({2'b00, a[NEXP+NSIG-1:NSIG]}) - $signed({2'b00, b[NEXP+NSIG-1:NSIG]});
            busy   <= 1'b1;
            state  <= DIVIDE;
          end
        end
        DIVIDE: if (count == LASTCNT) state <= NORM;
        NORM: begin
          q      <= normQ;
          qFlags <= normFlags;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - vector table plus handshake/reset sequences, scoreboard on done
module tb_fp_div;
  import fp_div_pkg::*;

  localparam int LAT = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic busy, done;
  logic [15:0] q;
  logic [NTYPES-1:0] qFlags;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0]       q;
    logic [NTYPES-1:0] f;
    int                doneCyc;
  } exp_t;

  typedef struct {
    logic [15:0]       a;
    logic [15:0]       b;
    logic [15:0]       q;
    logic [NTYPES-1:0] f;
    bit                spec;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];

  localparam logic [NTYPES-1:0] F_S = 6'b000001;
  localparam logic [NTYPES-1:0] F_Q = 6'b000010;
  localparam logic [NTYPES-1:0] F_I = 6'b000100;
  localparam logic [NTYPES-1:0] F_Z = 6'b001000;
  localparam logic [NTYPES-1:0] F_U = 6'b010000;
  localparam logic [NTYPES-1:0] F_N = 6'b100000;

  fp_div dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .qFlags(qFlags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 q=%h cycle=%0d", q, cyc);
      end else begin
        e = sb.pop_front();
        check("q", 32'(q), 32'(e.q));
        check("qFlags", 32'(qFlags), 32'(e.f));
        check("done_cycle", cyc, e.doneCyc);
      end
    end
  end

  task automatic pushExp(input logic [15:0] eq, input logic [NTYPES-1:0] ef, input bit spec);
    exp_t e;
    e.q = eq;
    e.f = ef;
    e.doneCyc = cyc + 1 + (spec ? 0 : LAT);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] eq,
                       input logic [NTYPES-1:0] ef, input bit spec, input bit push);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    if (push) pushExp(eq, ef, spec);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=done", name);
      sb.delete();
    end
  endtask

  initial begin
    int busyCnt;
    bit seen;

    vecs[0]  = '{16'h4600, 16'h4000, 16'h4200, F_N, 1'b0};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, F_N, 1'b0};
    vecs[2]  = '{16'hC600, 16'h4000, 16'hC200, F_N, 1'b0};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, F_I, 1'b1};
    vecs[4]  = '{16'h0000, 16'h0000, 16'h7E00, F_Q, 1'b1};
    vecs[5]  = '{16'h7D00, 16'h3C00, 16'h7D00, F_S, 1'b1};
    vecs[6]  = '{16'h3C00, 16'h7C00, 16'h0000, F_Z, 1'b1};
    vecs[7]  = '{16'h7BFF, 16'h1400, 16'h7C00, F_I, 1'b0};
    vecs[8]  = '{16'h0400, 16'h4000, 16'h0200, F_U, 1'b0};
    vecs[9]  = '{16'h0400, 16'h7BFF, 16'h0000, F_Z, 1'b0};
    vecs[10] = '{16'h7E00, 16'h7D00, 16'h7D00, F_S, 1'b1};
    vecs[11] = '{16'hFC00, 16'h7C00, 16'hFE00, F_Q, 1'b1};
    vecs[12] = '{16'h0001, 16'h3C00, 16'h0000, F_Z, 1'b1};
    vecs[13] = '{16'h3C00, 16'h8001, 16'hFC00, F_I, 1'b1};
    vecs[14] = '{16'h3C00, 16'h3C00, 16'h3C00, F_N, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_q", 32'(q), 32'd0);
    check("reset_qFlags", 32'(qFlags), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f, vecs[i].spec, 1'b1);
      waitIdle("vector");
    end

    // busy must span exactly the 13-cycle normal latency
    issue(16'h4600, 16'h4000, 16'h4200, F_N, 1'b0, 1'b1);
    busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busyCnt++;
      @(negedge clk);
    end
    check("busy_cycles", busyCnt, LAT);
    waitIdle("busy");

    // starts during busy are ignored, including one that would be a special case
    issue(16'hC600, 16'h4000, 16'hC200, F_N, 1'b0, 1'b1);
    @(negedge clk);
    a = 16'h3C00; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 16'h3C00; b = 16'h4200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle("ignore");
    repeat (3) @(negedge clk);
    check("q_held", 32'(q), 32'h0000C200);

    // start in the done cycle launches the next operation
    issue(16'h3C00, 16'h4200, 16'h3555, F_N, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done", 32'(seen), 32'd1);
    a = 16'h4600; b = 16'h4000; start = 1'b1;
    pushExp(16'h4200, F_N, 1'b0);
    @(negedge clk);
    start = 1'b0;
    waitIdle("b2b");

    // asynchronous reset mid-operation clears outputs at once and drops the result
    issue(16'h3C00, 16'h4200, 16'h3555, F_N, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_qFlags", 32'(qFlags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(16'h4600, 16'h4000, 16'h4200, F_N, 1'b0, 1'b1);
    waitIdle("post_reset");
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
Iterative IEEE-style floating-point divider, q = a / b, for the same NEXP/NSIG formats as the combinational multiplier (default half precision). It classifies both operands, resolves special cases in one cycle, and otherwise runs a restoring significand divider at one quotient bit per cycle. Results are truncated, with no rounding, and reported with the same one-hot class flags as the other fp_* arithmetic blocks. It sits beside fp_mul in the motion datapath behind a start/done handshake.

Parameters:
NEXP, 5, exponent field width
NSIG, 10, stored significand (fraction) width; the hidden bit is extra

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only while busy=0
a  in  NEXP+NSIG+1  dividend
b  in  NEXP+NSIG+1  divisor
busy  out  1  operation in progress
done  out  1  one-cycle pulse; q/qFlags valid from this cycle
q  out  NEXP+NSIG+1  quotient; held until the next accepted start
qFlags  out  NTYPES  one-hot class of q (SNAN, QNAN, INFINITY, ZERO, SUBNORMAL, NORMAL)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, q=0, qFlags=0. Reset during DIVIDE/NORM aborts the operation; no done is produced.
- Sign: qSign = aSign XOR bSign for every generated result. NaN propagation returns the operand unchanged.
- Edge T with start=1 and busy=0: a and b are classified (fp_class) and the special cases below are checked in priority order.
- Special cases: q, qFlags and done=1 are written at edge T; state stays IDLE; latency is 1.
  - Priority 1: a or b sNaN -> that operand (a wins), SNAN.
  - Priority 2: a or b qNaN -> that operand (a wins), QNAN.
  - Priority 3: inf/inf or 0/0 -> {qSign, all-ones exp, 1, zeros}, QNAN.
  - Priority 4: a inf, or b zero or subnormal -> signed infinity, INFINITY.
  - Priority 5: a zero or subnormal, or b inf -> signed zero, ZERO.
  - Subnormal operands are flushed to zero.
- Normal path, edge T: latch significands and t1Exp = aExp - bExp (signed NEXP+2). Set busy=1. Enter DIVIDE with remainder = aSig and counter = 0.
- DIVIDE: one restoring step per cycle for NSIG+2 cycles, producing quotient bits MSB first.
  - Each step: trial = rem - bSig. If trial >= 0, the quotient bit is 1 and rem becomes trial. Otherwise the quotient bit is 0 and rem is unchanged. rem is then shifted left 1.
  - After the last step, enter NORM.
- NORM (one cycle): the quotient is Qraw[NSIG+1:0], with Qraw = floor(aSig*2^(NSIG+1) / bSig).
  - If Qraw[NSIG+1]=1: tSig = Qraw[NSIG+1:1], t2Exp = t1Exp.
  - Else: tSig = Qraw[NSIG:0], t2Exp = t1Exp - 1.
  - Range check: t2Exp < EMIN-NSIG -> signed zero, ZERO. t2Exp < EMIN -> {qSign, zeros, (tSig >> (EMIN - t2Exp))[NSIG-1:0]}, SUBNORMAL. t2Exp > EMAX -> signed infinity, INFINITY. Otherwise {qSign, (t2Exp+BIAS)[NEXP-1:0], tSig[NSIG-1:0]}, NORMAL.
  - Write q/qFlags, done=1, busy=0, state=IDLE.
- Latency: start edge T, done high after edge T+NSIG+3 (13 cycles at default).
- start while busy=1 is ignored; no queuing.
- start in the cycle done=1 (state IDLE) is accepted; back-to-back operation is legal.
- done is high for exactly one cycle. It clears on the next edge unless a special-case start re-asserts it.
- All arithmetic inside the block is unsigned except exponents, which are signed NEXP+2 bits.

Decomposition:
- Shared constants (NTYPES, flag indices SNAN..NORMAL, BIAS, EMIN, EMAX) come from the existing flags include; no new constants are added there.
- Local state encoding: IDLE, DIVIDE, NORM.
- Reuse fp_class twice for operand classification.
- One natural sub-module: fp_sig_div, the sequential restoring significand divider with load/step/count outputs. The fp_div top keeps the special-case logic, FSM, exponent and packing.

Test Plan:
- 6.0/2.0: a=0x4600, b=0x4000 -> q=0x4200, qFlags=NORMAL, busy for 13 cycles, done pulse at cycle 13.
- 1.0/3.0: a=0x3C00, b=0x4200 -> q=0x3555, NORMAL. -6.0/2.0: a=0xC600 -> q=0xC200.
- Specials, each with done after 1 cycle:
  - 0x3C00/0x0000 -> 0x7C00, INFINITY.
  - 0x0000/0x0000 -> 0x7E00, QNAN.
  - 0x7D00/0x3C00 -> 0x7D00, SNAN.
  - 0x3C00/0x7C00 -> 0x0000, ZERO.
- Range: 0x7BFF/0x1400 -> 0x7C00, INFINITY. 0x0400/0x4000 -> 0x0200, SUBNORMAL. 0x0400/0x7BFF -> 0x0000, ZERO.
- Handshake: start pulsed again at cycles 3 and 7 of an operation is ignored and q is unchanged. Start in the done cycle launches a new operation whose done arrives 13 cycles later.
- Reset: rst_n low at cycle 5 of an operation -> outputs are 0 immediately (asynchronous), no done; a subsequent 6.0/2.0 completes normally.
